uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb.sv | 111 +++++++++++
 tb/tb_uart_tx_arb.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding four byte requesters into one UART transmitter.
// Grant-to-txStart is one cycle; requesters wait (req held) until their ack pulse.
module uart_tx_arb #(
   parameter int BUSY_TO = 8,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             nRst,
   input  logic [3:0]       req,
   input  logic [31:0]      reqData32,
   output logic [3:0]       ack,
   output logic [7:0]       txData8,
   output logic             txStart,
   input  logic             txBusy,
   output logic [1:0]       grantId,
   output logic             arbBusy,
   output logic             errBusyTo,
   output logic [CNT_W-1:0] txByteCnt
);

   localparam int TO_W = (BUSY_TO > 2) ? $clog2(BUSY_TO) : 1;
   localparam logic [TO_W-1:0] TO_MAX = TO_W'(BUSY_TO - 1);

   typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

   state_t           r_state;
   logic [3:0]       r_ack;
   logic [7:0]       r_txData8;
   logic             r_txStart;
   logic [1:0]       r_grantId;
   logic             r_err;
   logic [TO_W-1:0]  r_toCnt;
   logic [CNT_W-1:0] r_byteCnt;

   logic [1:0]       w_win;
   logic [1:0]       w_idx;
   logic             w_hit;

   // Search starts just above the last winner so every requester gets a turn.
   always_comb begin
      w_win = '0;
      w_hit = 1'b0;
      w_idx = '0;
      for (int i = 0; i < 4; i++) begin
         w_idx = r_grantId + 2'(i + 1);
         if (!w_hit && req[w_idx]) begin
            w_win = w_idx;
            w_hit = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         r_state   <= IDLE;
         r_ack     <= '0;
         r_txData8 <= 8'h00;
         r_txStart <= 1'b0;
         r_grantId <= 2'd3;
         r_err     <= 1'b0;
         r_toCnt   <= '0;
         r_byteCnt <= '0;
      end else begin
         r_ack     <= '0;
         r_txStart <= 1'b0;
         r_err     <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_hit) begin
                  r_txData8 <= reqData32[{w_win, 3'b000} +: 8];
                  r_ack     <= 4'b0001 << w_win;
                  r_grantId <= w_win;
                  r_txStart <= 1'b1;
                  r_state   <= START;
               end
            end
            START: begin
               r_toCnt <= '0;
               r_state <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (txBusy) begin
                  r_state <= WAIT_DONE;
               end else if (r_toCnt == TO_MAX) begin
                  // Transmitter never answered: drop the byte without counting it.
                  r_err   <= 1'b1;
                  r_state <= IDLE;
               end else begin
                  r_toCnt <= r_toCnt + 1'b1;
               end
            end
            WAIT_DONE: begin
               if (!txBusy) begin
                  r_byteCnt <= r_byteCnt + 1'b1;
                  r_state   <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign ack       = r_ack;
   assign txData8   = r_txData8;
   assign txStart   = r_txStart;
   assign grantId   = r_grantId;
   assign arbBusy   = (r_state != IDLE);
   assign errBusyTo = r_err;
   assign txByteCnt = r_byteCnt;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: grant scoreboard plus directed checks on timeout, reset and counter wrap.
module tb_uart_tx_arb;

   logic        clk = 1'b0;
   logic        nRst;
   logic [3:0]  req;
   logic [31:0] reqData32;
   logic [3:0]  ack;
   logic [7:0]  txData8;
   logic        txStart;
   logic        txBusy;
   logic [1:0]  grantId;
   logic        arbBusy;
   logic        errBusyTo;
   logic [3:0]  txByteCnt;

   uart_tx_arb #(.BUSY_TO(8), .CNT_W(4)) dut (
      .clk       (clk),
      .nRst      (nRst),
      .req       (req),
      .reqData32 (reqData32),
      .ack       (ack),
      .txData8   (txData8),
      .txStart   (txStart),
      .txBusy    (txBusy),
      .grantId   (grantId),
      .arbBusy   (arbBusy),
      .errBusyTo (errBusyTo),
      .txByteCnt (txByteCnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] a;
      logic [1:0] id;
      logic [7:0] d;
   } grant_t;

   grant_t exp_q[$];
   int     tests = 0;
   int     fails = 0;
   int     n_start = 0;
   logic   prev_busy = 1'b0;
   int     busy_en = 1;
   int     dly = 0;
   int     hold = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic push(input logic [3:0] a, input logic [1:0] id, input logic [7:0] d);
      grant_t g;
      g.a = a; g.id = id; g.d = d;
      exp_q.push_back(g);
   endtask

   // Requesters drop on ack; UART model raises txBusy 2 cycles after txStart for 10 cycles.
   task automatic tick();
      @(negedge clk);
      if (nRst && ack != 4'b0) req = req & ~ack;
      if (busy_en != 0) begin
         if (dly > 0) begin
            dly--;
            if (dly == 0) begin
               txBusy = 1'b1;
               hold = 10;
            end
         end else if (hold > 0) begin
            hold--;
            if (hold == 0) txBusy = 1'b0;
         end
         if (txStart) dly = 2;
      end
   endtask

   task automatic serve();
      int n = 0;
      while ((req != 4'b0 || arbBusy) && n < 300) begin
         tick();
         n++;
      end
      if (n >= 300) begin
         fails++;
         $display("FAIL serve_timeout: got req=%0h arbBusy=%0b expected idle", req, arbBusy);
      end
   endtask

   task automatic model_reset();
      txBusy = 1'b0;
      dly = 0;
      hold = 0;
   endtask

   always @(negedge clk) begin
      if (nRst) begin
         if (txStart) n_start++;
         if (ack != 4'b0) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_ack: got %0h expected none", ack);
            end else begin
               grant_t g;
               g = exp_q.pop_front();
               chk("ack", 32'(ack), 32'(g.a));
               chk("grantId", 32'(grantId), 32'(g.id));
               chk("txData8", 32'(txData8), 32'(g.d));
               chk("txStart_with_ack", 32'(txStart), 32'd1);
               chk("ack_prev_idle", 32'(prev_busy), 32'd0);
            end
         end
      end
      prev_busy = arbBusy;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      nRst = 1'b0;
      req = 4'b0;
      reqData32 = 32'h0;
      txBusy = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_txStart", 32'(txStart), 32'd0);
      chk("rst_err", 32'(errBusyTo), 32'd0);
      chk("rst_txData8", 32'(txData8), 32'h00);
      chk("rst_grantId", 32'(grantId), 32'd3);
      chk("rst_cnt", 32'(txByteCnt), 32'd0);
      chk("rst_arbBusy", 32'(arbBusy), 32'd0);
      nRst = 1'b1;

      // Single byte
      reqData32 = 32'h0000_00A5;
      req = 4'b0001;
      push(4'b0001, 2'd0, 8'hA5);
      serve();
      chk("single_cnt", 32'(txByteCnt), 32'd1);
      chk("single_grantId", 32'(grantId), 32'd0);
      chk("single_txData8", 32'(txData8), 32'hA5);
      chk("single_nstart", 32'(n_start), 32'd1);

      // All four requesting from reset: plain rotation
      @(negedge clk); nRst = 1'b0; model_reset();
      @(negedge clk); nRst = 1'b1;
      reqData32 = 32'h4433_2211;
      req = 4'b1111;
      push(4'b0001, 2'd0, 8'h11);
      push(4'b0010, 2'd1, 8'h22);
      push(4'b0100, 2'd2, 8'h33);
      push(4'b1000, 2'd3, 8'h44);
      serve();
      chk("rr_cnt", 32'(txByteCnt), 32'd4);

      // Wrap from requester 1 back to 0
      reqData32 = 32'h0000_5A00;
      req = 4'b0010;
      push(4'b0010, 2'd1, 8'h5A);
      serve();
      reqData32 = 32'h0000_F00F;
      req = 4'b0011;
      push(4'b0001, 2'd0, 8'h0F);
      push(4'b0010, 2'd1, 8'hF0);
      serve();
      chk("wrap_cnt", 32'(txByteCnt), 32'd7);

      // Transmitter never goes busy
      busy_en = 0;
      reqData32 = 32'h00C3_0000;
      req = 4'b0100;
      push(4'b0100, 2'd2, 8'hC3);
      n = 0;
      while (!txStart && n < 50) begin tick(); n++; end
      chk("to_saw_start", 32'(txStart), 32'd1);
      n = 0;
      while (!errBusyTo && n < 30) begin tick(); n++; end
      chk("to_delay", 32'(n), 32'd9);
      chk("to_err", 32'(errBusyTo), 32'd1);
      chk("to_idle", 32'(arbBusy), 32'd0);
      chk("to_cnt", 32'(txByteCnt), 32'd7);
      tick();
      chk("to_err_pulse", 32'(errBusyTo), 32'd0);
      busy_en = 1;

      // Reset in the middle of WAIT_DONE
      reqData32 = 32'h9900_0000;
      req = 4'b1000;
      push(4'b1000, 2'd3, 8'h99);
      n = 0;
      while (!txBusy && n < 50) begin tick(); n++; end
      tick();
      tick();
      chk("mid_busy", 32'(arbBusy), 32'd1);
      nRst = 1'b0;
      #1;
      chk("mid_rst_ack", 32'(ack), 32'd0);
      chk("mid_rst_txStart", 32'(txStart), 32'd0);
      chk("mid_rst_err", 32'(errBusyTo), 32'd0);
      chk("mid_rst_txData8", 32'(txData8), 32'h00);
      chk("mid_rst_grantId", 32'(grantId), 32'd3);
      chk("mid_rst_cnt", 32'(txByteCnt), 32'd0);
      chk("mid_rst_arbBusy", 32'(arbBusy), 32'd0);
      model_reset();
      @(negedge clk);
      nRst = 1'b1;
      reqData32 = 32'h7700_0066;
      req = 4'b1001;
      push(4'b0001, 2'd0, 8'h66);
      push(4'b1000, 2'd3, 8'h77);
      serve();
      chk("post_rst_cnt", 32'(txByteCnt), 32'd2);

      // Counter wrap at 2^CNT_W
      for (int i = 0; i < 14; i++) begin
         reqData32 = {24'h0, 8'(i + 1)};
         req = 4'b0001;
         push(4'b0001, 2'd0, 8'(i + 1));
         serve();
         if (i == 12) chk("cnt_max", 32'(txByteCnt), 32'd15);
      end
      chk("cnt_wrap", 32'(txByteCnt), 32'd0);

      repeat (3) @(negedge clk);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
